// File: rtl/ps2_mouse_packetizer.sv
// PS/2 mouse front end: enables data reporting with 0xF4 and waits for the 0xFA ACK.
// It then frames the 3-byte movement stream into registered Status/X/Y bytes with a trig_en pulse.
module ps2_mouse_packetizer #(
   parameter int          TIMEOUT_CYC = 2_500_000,
   parameter int          MAX_TRIES   = 3,
   parameter logic [7:0]  EN_CMD      = 8'hF4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   input  logic       tx_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [7:0] StatusByte,
   output logic [7:0] XByte,
   output logic [7:0] YByte,
   output logic       trig_en,
   output logic       streaming,
   output logic       init_fail
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int CW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      SEND_EN,
      WAIT_ACK,
      BYTE0,
      BYTE1,
      BYTE2,
      FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] try_q, try_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    status_sh_q, status_sh_d;
   logic [7:0]    x_sh_q, x_sh_d;
   logic [7:0]    status_q, status_d;
   logic [7:0]    x_q, x_d;
   logic [7:0]    y_q, y_d;
   logic          trig_q, trig_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          streaming_q, streaming_d;
   logic          init_fail_q, init_fail_d;
   logic          timeout;
   logic          retry_ok;

   assign timeout  = (timer_q == TMAX);
   assign retry_ok = (try_q < CW'(MAX_TRIES));

   always_comb begin
      state_d     = state_q;
      try_d       = try_q;
      timer_d     = timer_q;
      status_sh_d = status_sh_q;
      x_sh_d      = x_sh_q;
      status_d    = status_q;
      x_d         = x_q;
      y_d         = y_q;
      trig_d      = 1'b0;
      tx_start_d  = 1'b0;
      tx_data_d   = 8'h00;
      streaming_d = streaming_q;
      init_fail_d = init_fail_q;

      case (state_q)
         SEND_EN: begin
            if (tx_ready) begin
               tx_start_d = 1'b1;
               tx_data_d  = EN_CMD;
               try_d      = try_q + CW'(1);
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (rx_valid && !rx_err && rx_data == 8'hFA) begin
               state_d     = BYTE0;
               streaming_d = 1'b1;
            end else if (rx_valid || rx_err || timeout) begin
               if (retry_ok) begin
                  state_d = SEND_EN;
               end else begin
                  state_d     = FAIL;
                  init_fail_d = 1'b1;
               end
            end
         end
         BYTE0: begin
            // Bit 3 of a genuine status byte is always 1; anything else is a resync discard.
            if (!rx_err && rx_valid && rx_data[3]) begin
               status_sh_d = rx_data;
               state_d     = BYTE1;
            end
         end
         BYTE1: begin
            if (rx_err || (!rx_valid && timeout)) begin
               state_d = BYTE0;
            end else if (rx_valid) begin
               x_sh_d  = rx_data;
               state_d = BYTE2;
            end
         end
         BYTE2: begin
            if (rx_err || (!rx_valid && timeout)) begin
               state_d = BYTE0;
            end else if (rx_valid) begin
               status_d = status_sh_q;
               x_d      = x_sh_q;
               y_d      = rx_data;
               trig_d   = 1'b1;
               state_d  = BYTE0;
            end
         end
         FAIL: begin
            init_fail_d = 1'b1;
         end
         default: begin
            state_d = SEND_EN;
         end
      endcase

      // Timer restarts on any byte or state change and saturates rather than wrapping.
      if (rx_valid || state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == WAIT_ACK || state_q == BYTE1 || state_q == BYTE2) &&
                   timer_q != '1) begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEND_EN;
         try_q       <= '0;
         timer_q     <= '0;
         status_sh_q <= 8'h00;
         x_sh_q      <= 8'h00;
         status_q    <= 8'h00;
         x_q         <= 8'h00;
         y_q         <= 8'h00;
         trig_q      <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         streaming_q <= 1'b0;
         init_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         try_q       <= try_d;
         timer_q     <= timer_d;
         status_sh_q <= status_sh_d;
         x_sh_q      <= x_sh_d;
         status_q    <= status_d;
         x_q         <= x_d;
         y_q         <= y_d;
         trig_q      <= trig_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         streaming_q <= streaming_d;
         init_fail_q <= init_fail_d;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign StatusByte = status_q;
   assign XByte      = x_q;
   assign YByte      = y_q;
   assign trig_en    = trig_q;
   assign streaming  = streaming_q;
   assign init_fail  = init_fail_q;

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Directed bench for ps2_mouse_packetizer: a per-cycle vector table for the handshake and packet
// framing, plus hand-written sequences for timeouts and the init retry/fail path.
module tb_ps2_mouse_packetizer;

   localparam int TO = 16;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       tx_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] StatusByte;
   logic [7:0] XByte;
   logic [7:0] YByte;
   logic       trig_en;
   logic       streaming;
   logic       init_fail;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ps2_mouse_packetizer #(.TIMEOUT_CYC(TO), .MAX_TRIES(3), .EN_CMD(8'hF4)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
      .StatusByte(StatusByte), .XByte(XByte), .YByte(YByte), .trig_en(trig_en),
      .streaming(streaming), .init_fail(init_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic       txr;
      logic       vld;
      logic       err;
      logic [7:0] rx;
      logic       e_txs;
      logic       e_str;
      logic       e_trig;
      logic [7:0] e_st;
      logic [7:0] e_x;
      logic [7:0] e_y;
      logic       e_fail;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic r, logic t, logic v, logic e, logic [7:0] d,
                               logic xs, logic s, logic tg, logic [7:0] a, logic [7:0] b,
                               logic [7:0] c, logic f);
      vec_t x;
      x.name = n; x.rst = r; x.txr = t; x.vld = v; x.err = e; x.rx = d;
      x.e_txs = xs; x.e_str = s; x.e_trig = tg; x.e_st = a; x.e_x = b; x.e_y = c;
      x.e_fail = f;
      return x;
   endfunction

   // Drive inputs on the falling edge, let one rising edge pass, then settle before sampling.
   task automatic applyStimulus(input logic r, input logic t, input logic v, input logic e,
                                input logic [7:0] d);
      @(negedge clk);
      rst = r; tx_ready = t; rx_valid = v; rx_err = e; rx_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %02h expected %02h", nm, act, exp);
   endtask

   task automatic checkPacket(input string nm, input logic tg, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c);
      checkOutput({nm, ".trig_en"}, {7'b0, trig_en}, {7'b0, tg});
      checkOutput({nm, ".Status"}, StatusByte, a);
      checkOutput({nm, ".X"}, XByte, b);
      checkOutput({nm, ".Y"}, YByte, c);
   endtask

   task automatic idleNoTrig(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         checkOutput(nm, {7'b0, trig_en}, 8'h00);
      end
   endtask

   task automatic sendByte(input logic [7:0] d);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, d);
   endtask

   initial begin
      int txs_cnt;

      rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;

      vecs.push_back(mk("reset",      1,0,0,0,8'h00, 0,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("no_ready",   0,0,0,0,8'h00, 0,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("send_f4",    0,1,0,0,8'h00, 1,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("one_pulse",  0,1,0,0,8'h00, 0,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("ack",        0,1,1,0,8'hFA, 0,1,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("p1_b0",      0,1,1,0,8'h08, 0,1,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("p1_b1",      0,1,1,0,8'h05, 0,1,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("p1_b2",      0,1,1,0,8'hFB, 0,1,1,8'h08,8'h05,8'hFB,0));
      vecs.push_back(mk("p1_hold",    0,1,0,0,8'h00, 0,1,0,8'h08,8'h05,8'hFB,0));
      vecs.push_back(mk("resync_02",  0,1,1,0,8'h02, 0,1,0,8'h08,8'h05,8'hFB,0));
      vecs.push_back(mk("p2_b0",      0,1,1,0,8'h18, 0,1,0,8'h08,8'h05,8'hFB,0));
      vecs.push_back(mk("p2_b1",      0,1,1,0,8'h7F, 0,1,0,8'h08,8'h05,8'hFB,0));
      vecs.push_back(mk("p2_b2",      0,1,1,0,8'h01, 0,1,1,8'h18,8'h7F,8'h01,0));
      vecs.push_back(mk("p2_hold",    0,1,0,0,8'h00, 0,1,0,8'h18,8'h7F,8'h01,0));
      vecs.push_back(mk("p3_b0",      0,1,1,0,8'h08, 0,1,0,8'h18,8'h7F,8'h01,0));
      vecs.push_back(mk("p3_fa",      0,1,1,0,8'hFA, 0,1,0,8'h18,8'h7F,8'h01,0));
      vecs.push_back(mk("p3_aa",      0,1,1,0,8'hAA, 0,1,1,8'h08,8'hFA,8'hAA,0));
      vecs.push_back(mk("err_b0",     0,1,1,0,8'h09, 0,1,0,8'h08,8'hFA,8'hAA,0));
      vecs.push_back(mk("err_vld",    0,1,1,1,8'h33, 0,1,0,8'h08,8'hFA,8'hAA,0));
      vecs.push_back(mk("p4_b0",      0,1,1,0,8'h0A, 0,1,0,8'h08,8'hFA,8'hAA,0));
      vecs.push_back(mk("p4_b1",      0,1,1,0,8'h11, 0,1,0,8'h08,8'hFA,8'hAA,0));
      vecs.push_back(mk("p4_b2",      0,1,1,0,8'h22, 0,1,1,8'h0A,8'h11,8'h22,0));
      vecs.push_back(mk("p4_hold",    0,1,0,0,8'h00, 0,1,0,8'h0A,8'h11,8'h22,0));
      vecs.push_back(mk("p5_b0",      0,1,1,0,8'h08, 0,1,0,8'h0A,8'h11,8'h22,0));
      vecs.push_back(mk("p5_b1",      0,1,1,0,8'h01, 0,1,0,8'h0A,8'h11,8'h22,0));
      vecs.push_back(mk("rst_b2",     1,1,1,0,8'h02, 0,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("resend_f4",  0,1,0,0,8'h00, 1,0,0,8'h00,8'h00,8'h00,0));
      vecs.push_back(mk("resend_end", 0,1,0,0,8'h00, 0,0,0,8'h00,8'h00,8'h00,0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].txr, vecs[i].vld, vecs[i].err, vecs[i].rx);
         checkOutput({vecs[i].name, ".tx_start"}, {7'b0, tx_start}, {7'b0, vecs[i].e_txs});
         if (vecs[i].e_txs) checkOutput({vecs[i].name, ".tx_data"}, tx_data, 8'hF4);
         checkOutput({vecs[i].name, ".streaming"}, {7'b0, streaming}, {7'b0, vecs[i].e_str});
         checkOutput({vecs[i].name, ".init_fail"}, {7'b0, init_fail}, {7'b0, vecs[i].e_fail});
         checkPacket(vecs[i].name, vecs[i].e_trig, vecs[i].e_st, vecs[i].e_x, vecs[i].e_y);
      end

      // Partial packet abandoned in BYTE2 after TO silent cycles, then a clean packet.
      sendByte(8'hFA);
      checkOutput("ack2.streaming", {7'b0, streaming}, 8'h01);
      sendByte(8'h09);
      sendByte(8'h10);
      idleNoTrig("to_b2.idle", TO);
      sendByte(8'h08);
      checkOutput("to_b2.b0", {7'b0, trig_en}, 8'h00);
      sendByte(8'h01);
      checkOutput("to_b2.b1", {7'b0, trig_en}, 8'h00);
      sendByte(8'h02);
      checkPacket("to_b2.pkt", 1'b1, 8'h08, 8'h01, 8'h02);
      idleNoTrig("to_b2.after", 2);

      // Partial packet abandoned in BYTE1.
      sendByte(8'h09);
      idleNoTrig("to_b1.idle", TO);
      sendByte(8'h0C);
      sendByte(8'h03);
      checkOutput("to_b1.b1", {7'b0, trig_en}, 8'h00);
      sendByte(8'h04);
      checkPacket("to_b1.pkt", 1'b1, 8'h0C, 8'h03, 8'h04);

      // A gap shorter than the timeout must not break the packet.
      sendByte(8'h09);
      sendByte(8'h10);
      idleNoTrig("gap.idle", TO - 2);
      sendByte(8'h33);
      checkPacket("gap.pkt", 1'b1, 8'h09, 8'h10, 8'h33);

      // No ACK ever: three attempts, then a sticky failure that ignores a late ACK.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("fail.reset_streaming", {7'b0, streaming}, 8'h00);
      txs_cnt = 0;
      for (int i = 0; i < 8 * TO; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         if (tx_start) begin
            txs_cnt++;
            checkOutput("fail.tx_data", tx_data, 8'hF4);
         end
      end
      checkOutput("fail.tx_start_count", 8'(txs_cnt), 8'd3);
      checkOutput("fail.init_fail", {7'b0, init_fail}, 8'h01);
      sendByte(8'hFA);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("fail.ignore_ack", {7'b0, streaming}, 8'h00);
      checkOutput("fail.no_tx", {7'b0, tx_start}, 8'h00);
      checkOutput("fail.sticky", {7'b0, init_fail}, 8'h01);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
